// File: rtl/acorn128_tag_verify.sv
// ---------------------------------------------------------------------------
// acorn128_tag_verify
//
// Purpose:
//   Post-processing stage for an ACORN-128 decryption core. When the core
//   raises ready_in, the decrypted block and both tags are latched. The
//   computed tag and the received tag are then compared in constant time,
//   CMP_WIDTH bits per cycle, MSB chunk first. The authentication verdict
//   and the plaintext are held until the consumer acknowledges them.
//
// Parameters:
//   CMP_WIDTH        tag bits compared per cycle (8, 16, 32, 64 or 128)
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous reset, active-high
//   ready_in         level-high "result available" from the core
//   text_in          decrypted block from the core
//   tag_in           tag computed by the core
//   expected_tag_in  tag received with the message
//   ack_in           consumer accepts the current result
//   plaintext_out    released plaintext (zero outside RESULT)
//   valid_out        result fields valid, held until ack_in
//   auth_ok_out      tag matched (valid only with valid_out)
//   auth_fail_out    tag mismatched (valid only with valid_out)
//   busy_out         high while an operation is in progress
//
// Configuration:
//   ACORN_TAG_MASK_EN  when defined, plaintext is suppressed (and the
//                      internal text register wiped) on an auth failure.
// ---------------------------------------------------------------------------
module acorn128_tag_verify #(
  parameter int CMP_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ready_in,
  input  logic [127:0] text_in,
  input  logic [127:0] tag_in,
  input  logic [127:0] expected_tag_in,
  input  logic         ack_in,
  output logic [127:0] plaintext_out,
  output logic         valid_out,
  output logic         auth_ok_out,
  output logic         auth_fail_out,
  output logic         busy_out
);

  localparam int NUM_CHUNKS = 128 / CMP_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [127:0]       text_r;
  logic [127:0]       tag_r;
  logic [127:0]       exp_r;
  logic [IDX_W-1:0]   idx;
  logic               diff;
  logic               ready_q;
  logic               armed;

  logic               rise;
  logic               last_chunk;
  logic [CMP_WIDTH-1:0] chunk_xor;
  logic               diff_next;
  logic               in_result;

  // A rise only counts once ready_in has been seen low since reset, so a
  // level that was already high when reset released never triggers.
  assign rise       = ready_in & ~ready_q & armed;
  assign last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));
  assign in_result  = (state == RESULT);

  // Chunk select written as a loop of constant slices so the mux has no
  // variable part-select; chunk 0 is the most significant slice.
  always_comb begin
    chunk_xor = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx == IDX_W'(i)) begin
        chunk_xor = tag_r[(NUM_CHUNKS-1-i)*CMP_WIDTH +: CMP_WIDTH]
                  ^ exp_r[(NUM_CHUNKS-1-i)*CMP_WIDTH +: CMP_WIDTH];
      end
    end
  end

  assign diff_next = diff | (|chunk_xor);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // COMPARE always runs the full chunk count regardless of mismatches so
  // the verdict latency does not leak where the tags differ.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = CAPTURE;
      CAPTURE: state_next = COMPARE;
      COMPARE: if (last_chunk) state_next = RESULT;
      RESULT:  if (ack_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      text_r  <= '0;
      tag_r   <= '0;
      exp_r   <= '0;
      idx     <= '0;
      diff    <= 1'b0;
      ready_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      ready_q <= ready_in;
      if (!ready_in) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (rise) begin
            text_r <= text_in;
            tag_r  <= tag_in;
            exp_r  <= expected_tag_in;
          end
        end
        CAPTURE: begin
          idx  <= '0;
          diff <= 1'b0;
        end
        COMPARE: begin
          diff <= diff_next;
          idx  <= idx + IDX_W'(1);
`ifdef ACORN_TAG_MASK_EN
          // Wipe the unauthenticated plaintext as the verdict is formed.
          if (last_chunk && diff_next) begin
            text_r <= '0;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    valid_out     = in_result;
    auth_ok_out   = in_result & ~diff;
    auth_fail_out = in_result & diff;
    busy_out      = (state != IDLE);
`ifdef ACORN_TAG_MASK_EN
    plaintext_out = (in_result && !diff) ? text_r : '0;
`else
    plaintext_out = in_result ? text_r : '0;
`endif
  end

endmodule

// File: tb/tb_acorn128_tag_verify.sv
// ---------------------------------------------------------------------------
// tb_acorn128_tag_verify
//
// Purpose:
//   Self-checking bench for acorn128_tag_verify at the default CMP_WIDTH.
//   Stimulus pushes the hand-computed verdict into a scoreboard queue; a
//   monitor pops it when valid_out rises and checks verdict, plaintext and
//   latency, then checks the outputs stay stable while valid_out is held.
// ---------------------------------------------------------------------------
module tb_acorn128_tag_verify;

  localparam int CMP_WIDTH = 32;
  localparam int LATENCY   = 2 + 128 / CMP_WIDTH;

  localparam logic [127:0] TAG_A  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] TAG_L  = 128'h0123456789ABCDEF0123456789ABCDEE;
  localparam logic [127:0] TAG_M  = 128'h8123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] TAG_X  = 128'hFFFFFFFF00000000FFFFFFFF00000000;
  localparam logic [127:0] TEXT_A = 128'hAABBCCDDEEFF00112233445566778899;
  localparam logic [127:0] TEXT_B = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] TEXT_X = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

  typedef struct {
    logic [127:0] text;
    logic         ok;
    logic         fail;
    int           cycle;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         ready_in;
  logic [127:0] text_in;
  logic [127:0] tag_in;
  logic [127:0] expected_tag_in;
  logic         ack_in;
  logic [127:0] plaintext_out;
  logic         valid_out;
  logic         auth_ok_out;
  logic         auth_fail_out;
  logic         busy_out;

  int   checks;
  int   failures;
  int   cyc;
  exp_t sb[$];
  exp_t cur;
  logic haveCur;
  logic prevValid;

  acorn128_tag_verify #(.CMP_WIDTH(CMP_WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .ready_in        (ready_in),
    .text_in         (text_in),
    .tag_in          (tag_in),
    .expected_tag_in (expected_tag_in),
    .ack_in          (ack_in),
    .plaintext_out   (plaintext_out),
    .valid_out       (valid_out),
    .auth_ok_out     (auth_ok_out),
    .auth_fail_out   (auth_fail_out),
    .busy_out        (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [127:0] expText(input logic [127:0] text, input logic ok);
`ifdef ACORN_TAG_MASK_EN
    return ok ? text : 128'h0;
`else
    return text;
`endif
  endfunction

  // Drives a fresh rise on ready_in with the given operands and, when a
  // result is expected, queues the hand-computed verdict.
  task automatic applyStimulus(input logic [127:0] text, input logic [127:0] tag,
                               input logic [127:0] expTag, input logic ok,
                               input logic pushIt);
    exp_t e;
    @(posedge clk); #1;
    text_in         = text;
    tag_in          = tag;
    expected_tag_in = expTag;
    ready_in        = 1'b1;
    if (pushIt) begin
      e.text  = expText(text, ok);
      e.ok    = ok;
      e.fail  = ~ok;
      e.cycle = cyc + LATENCY;
      sb.push_back(e);
    end
  endtask

  task automatic waitValid(input string name);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (valid_out) break;
    end
    checkOutput(name, {127'h0, valid_out}, 128'h1);
  endtask

  task automatic ackPulse(input string name);
    @(posedge clk); #1;
    ack_in = 1'b1;
    @(posedge clk); #1;
    ack_in = 1'b0;
    checkOutput(name, {126'h0, valid_out, busy_out}, 128'h0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  // Monitor: pops on each valid_out rise, then holds the popped entry and
  // checks every later cycle of RESULT against it.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
      haveCur   = 1'b0;
    end else begin
      if (valid_out && !prevValid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 128'h1, 128'h0);
          haveCur = 1'b0;
        end else begin
          cur     = sb.pop_front();
          haveCur = 1'b1;
          checkOutput("latency", 128'(cyc), 128'(cur.cycle));
        end
      end
      if (valid_out && haveCur) begin
        checkOutput("auth_ok", {127'h0, auth_ok_out}, {127'h0, cur.ok});
        checkOutput("auth_fail", {127'h0, auth_fail_out}, {127'h0, cur.fail});
        checkOutput("plaintext", plaintext_out, cur.text);
        checkOutput("busy_in_result", {127'h0, busy_out}, 128'h1);
      end
      if (!valid_out) begin
        haveCur = 1'b0;
        checkOutput("idle_outputs_zero",
                    plaintext_out | {126'h0, auth_ok_out, auth_fail_out}, 128'h0);
      end
      prevValid = valid_out;
    end
  end

  initial begin
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    haveCur         = 1'b0;
    prevValid       = 1'b0;
    rst             = 1'b1;
    ready_in        = 1'b1;
    ack_in          = 1'b0;
    text_in         = TEXT_X;
    tag_in          = TAG_X;
    expected_tag_in = TAG_A;

    // Reset with ready_in already high: must not be seen as a rise.
    idleCycles(3);
    checkOutput("reset_outputs",
                plaintext_out | {124'h0, valid_out, auth_ok_out, auth_fail_out, busy_out},
                128'h0);
    rst = 1'b0;
    idleCycles(8);
    checkOutput("no_rise_after_reset", {127'h0, busy_out}, 128'h0);
    ready_in = 1'b0;
    idleCycles(2);

    // Full match.
    applyStimulus(TEXT_A, TAG_A, TAG_A, 1'b1, 1'b1);
    waitValid("match_valid");
    ready_in = 1'b0;
    ackPulse("match_ack");
    idleCycles(2);

    // Mismatch only in bit 0 (last chunk compared).
    applyStimulus(TEXT_A, TAG_A, TAG_L, 1'b0, 1'b1);
    waitValid("lsb_valid");
    ready_in = 1'b0;
    ackPulse("lsb_ack");
    idleCycles(2);

    // Mismatch only in bit 127 (first chunk compared), same latency.
    applyStimulus(TEXT_B, TAG_A, TAG_M, 1'b0, 1'b1);
    waitValid("msb_valid");
    ready_in = 1'b0;
    ackPulse("msb_ack");
    idleCycles(2);

    // Handshake: hold ack low 10 cycles with ready_in kept high throughout.
    applyStimulus(TEXT_B, TAG_M, TAG_M, 1'b1, 1'b1);
    waitValid("hold_valid");
    idleCycles(10);
    checkOutput("hold_still_valid", {127'h0, valid_out}, 128'h1);
    ackPulse("hold_ack");
    idleCycles(10);
    checkOutput("no_second_result", {127'h0, busy_out}, 128'h0);
    ready_in = 1'b0;
    idleCycles(2);

    // Reset during the second COMPARE cycle.
    applyStimulus(TEXT_X, TAG_X, TAG_A, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("busy_before_reset", {127'h0, busy_out}, 128'h1);
    rst = 1'b1;
    idleCycles(1);
    checkOutput("mid_reset_outputs",
                plaintext_out | {124'h0, valid_out, auth_ok_out, auth_fail_out, busy_out},
                128'h0);
    rst      = 1'b0;
    ready_in = 1'b0;
    idleCycles(2);
    applyStimulus(TEXT_A, TAG_L, TAG_L, 1'b1, 1'b1);
    waitValid("post_reset_valid");
    ready_in = 1'b0;
    ackPulse("post_reset_ack");
    idleCycles(2);

    // Second rise during COMPARE with different operands is ignored.
    applyStimulus(TEXT_A, TAG_A, TAG_A, 1'b1, 1'b1);
    idleCycles(2);
    ready_in = 1'b0;
    idleCycles(1);
    text_in         = TEXT_X;
    tag_in          = TAG_X;
    expected_tag_in = TAG_A;
    ready_in        = 1'b1;
    waitValid("busy_reject_valid");
    ackPulse("busy_reject_ack");
    ready_in = 1'b0;
    idleCycles(4);

    checkOutput("scoreboard_drained", 128'(sb.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
